note_player: RTL

NOTE_PLAYER -- requirements
Module: note_player

---
 rtl/tune_pkg.sv | 39 +++
 rtl/tune_period_lut.sv | 36 +++
 rtl/note_player.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/tune_pkg.sv
// Shared definitions for the note player: tune field layout, octave-1 base periods
// (in 50 MHz clocks) and the player FSM state encoding.
package tune_pkg;

    localparam int TUNE_W = 8;
    localparam int OCT_HI = 7;
    localparam int OCT_LO = 4;
    localparam int DEG_HI = 3;
    localparam int DEG_LO = 0;
    localparam int FIELD_W = 4;
    localparam int BASE_W = 20;

    localparam logic [FIELD_W-1:0] DEG_REST = 4'd0;
    localparam logic [FIELD_W-1:0] DEG_MAX  = 4'd7;
    localparam logic [FIELD_W-1:0] OCT_MIN  = 4'd1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_GAP  = 2'd2
    } state_e;

    // Degrees outside do..xi return zero; callers flag them separately.
    function automatic logic [BASE_W-1:0] base_period(input logic [FIELD_W-1:0] degree);
        logic [BASE_W-1:0] p;
        case (degree)
            4'd1:    p = 20'h2EA9B;
            4'd2:    p = 20'h29902;
            4'd3:    p = 20'h25093;
            4'd4:    p = 20'h22F50;
            4'd5:    p = 20'h1F23F;
            4'd6:    p = 20'h1BBE4;
            4'd7:    p = 20'h18B73;
            default: p = '0;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/tune_period_lut.sv
// Combinational decode of a tune code into a tone period in clocks, plus an
// illegal-code flag. Rests and illegal codes both yield period 0.
module tune_period_lut
    import tune_pkg::*;
#(
    parameter int PERIOD_W = 20,
    parameter int OCT_MAX  = 3
) (
    input  logic [TUNE_W-1:0]   note_tune_i,
    output logic [PERIOD_W-1:0] period_o,
    output logic                illegal_o
);

    localparam logic [FIELD_W-1:0] OCT_TOP = FIELD_W'(OCT_MAX);

    logic [FIELD_W-1:0] octave;
    logic [FIELD_W-1:0] degree;
    logic [BASE_W-1:0]  shifted;

    always_comb begin
        octave    = note_tune_i[OCT_HI:OCT_LO];
        degree    = note_tune_i[DEG_HI:DEG_LO];
        shifted   = base_period(degree) >> (octave - OCT_MIN);
        period_o  = '0;
        illegal_o = 1'b0;
        // Degree 0 is a plain rest regardless of the octave field.
        if (degree != DEG_REST) begin
            if (octave < OCT_MIN || octave > OCT_TOP || degree > DEG_MAX) begin
                illegal_o = 1'b1;
            end else begin
                period_o = PERIOD_W'(shifted);
            end
        end
    end

endmodule

// File: rtl/note_player.sv
// Buzzer note player: accepts one tune/duration request at a time, plays a square
// wave for the requested number of beats, then holds a silent gap before the next.
module note_player
    import tune_pkg::*;
#(
    parameter int PERIOD_W    = 20,
    parameter int DUR_W       = 8,
    parameter int BEAT_CYCLES = 2500000,
    parameter int GAP_CYCLES  = 250000,
    parameter int OCT_MAX     = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              note_valid,
    output logic              note_ready,
    input  logic [7:0]        note_tune,
    input  logic [DUR_W-1:0]  note_dur,
    input  logic              stop,
    output logic              pwm_out,
    output logic              busy,
    output logic              note_done,
    output logic              code_err
);

    localparam int BEAT_W = (BEAT_CYCLES > 1) ? $clog2(BEAT_CYCLES) : 1;
    localparam int GAP_W  = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BEAT_CYCLES - 1);
    localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    state_e              state_q, state_d;
    logic [PERIOD_W-1:0] period_q, period_d;
    logic [PERIOD_W-1:0] tone_q, tone_d;
    logic [DUR_W-1:0]    beats_left_q, beats_left_d;
    logic [BEAT_W-1:0]   beat_cnt_q, beat_cnt_d;
    logic [GAP_W-1:0]    gap_q, gap_d;
    logic                pwm_q, pwm_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic                ready_q;

    logic [PERIOD_W-1:0] lut_period;
    logic                lut_illegal;
    logic                accept;

    tune_period_lut #(
        .PERIOD_W (PERIOD_W),
        .OCT_MAX  (OCT_MAX)
    ) u_lut (
        .note_tune_i (note_tune),
        .period_o    (lut_period),
        .illegal_o   (lut_illegal)
    );

    assign note_ready = ready_q && (state_q == ST_IDLE);
    assign busy       = (state_q != ST_IDLE);
    assign accept     = note_valid && note_ready;
    assign pwm_out    = pwm_q;
    assign note_done  = done_q;
    assign code_err   = err_q;

    always_comb begin
        state_d      = state_q;
        period_d     = period_q;
        tone_d       = tone_q;
        beats_left_d = beats_left_q;
        beat_cnt_d   = beat_cnt_q;
        gap_d        = gap_q;
        done_d       = 1'b0;
        err_d        = 1'b0;

        // Stop overrides everything, including a same-cycle acceptance.
        if (stop) begin
            state_d      = ST_IDLE;
            period_d     = '0;
            tone_d       = '0;
            beats_left_d = '0;
            beat_cnt_d   = '0;
            gap_d        = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        period_d     = lut_period;
                        tone_d       = '0;
                        beats_left_d = note_dur;
                        beat_cnt_d   = '0;
                        gap_d        = '0;
                        err_d        = lut_illegal;
                        state_d      = (note_dur == '0) ? ST_GAP : ST_PLAY;
                    end
                end
                ST_PLAY: begin
                    if (period_q > PERIOD_W'(1) && tone_q != period_q - PERIOD_W'(1)) begin
                        tone_d = tone_q + PERIOD_W'(1);
                    end else begin
                        tone_d = '0;
                    end
                    if (beat_cnt_q == BEAT_LAST) begin
                        beat_cnt_d   = '0;
                        beats_left_d = beats_left_q - DUR_W'(1);
                        if (beats_left_q == DUR_W'(1)) begin
                            state_d = ST_GAP;
                            tone_d  = '0;
                            gap_d   = '0;
                        end
                    end else begin
                        beat_cnt_d = beat_cnt_q + BEAT_W'(1);
                    end
                end
                ST_GAP: begin
                    if (gap_q == GAP_LAST) begin
                        state_d = ST_IDLE;
                        gap_d   = '0;
                        done_d  = 1'b1;
                    end else begin
                        gap_d = gap_q + GAP_W'(1);
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        // Output is registered, so it is computed from the values the counters take next.
        pwm_d = (state_d == ST_PLAY) && (tone_d < (period_d >> 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            period_q     <= '0;
            tone_q       <= '0;
            beats_left_q <= '0;
            beat_cnt_q   <= '0;
            gap_q        <= '0;
            pwm_q        <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            ready_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            period_q     <= period_d;
            tone_q       <= tone_d;
            beats_left_q <= beats_left_d;
            beat_cnt_q   <= beat_cnt_d;
            gap_q        <= gap_d;
            pwm_q        <= pwm_d;
            done_q       <= done_d;
            err_q        <= err_d;
            ready_q      <= 1'b1;
        end
    end

endmodule
